t5_fetch: RTL

//  Multi-hart instruction fetch unit for the t5 barrel core; successor to the single-PC fetch stage.

---
 rtl/t5_fetch_pkg.sv | 14 +
 rtl/t5_fetch_if.sv | 26 ++
 rtl/t5_rrarb.sv | 31 +++
 rtl/t5_fetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/t5_fetch_pkg.sv
// rtl/t5_fetch_pkg.sv - shared constants for the t5 fetch unit
package t5_fetch_pkg;

   // Default datapath width, hart count and per-hart reset byte address
   localparam int          T5_XLEN      = 32;
   localparam int          T5_HARTS     = 4;
   localparam int          T5_HW        = $clog2(T5_HARTS);
   localparam logic [31:0] T5_RESET_VEC = 32'h0;

   // Fetch FSM: IDLE has no fetch outstanding, WAIT has exactly one
   localparam logic [0:0]  ST_IDLE      = 1'b0;
   localparam logic [0:0]  ST_WAIT      = 1'b1;

endpackage

// File: rtl/t5_fetch_if.sv
// rtl/t5_fetch_if.sv - instruction bus and decode-side bundle for t5_fetch
interface t5_fetch_if #(
   parameter int XLEN = 32,
   parameter int HW   = 2
);
   // Instruction bus: strobe held until ack, idat valid in the ack cycle
   logic            istb;
   logic [XLEN-3:0] iadr;
   logic            iack;
   logic [XLEN-1:0] idat;
   // Decode side: one-cycle valid with instruction, byte PC and hart id
   logic            ovld;
   logic [XLEN-1:0] oinst;
   logic [XLEN-1:0] opc;
   logic [HW-1:0]   ohart;

   modport master (
      output istb, iadr, ovld, oinst, opc, ohart,
      input  iack, idat
   );

   modport slave (
      input  istb, iadr, ovld, oinst, opc, ohart,
      output iack, idat
   );
endinterface

// File: rtl/t5_rrarb.sv
// rtl/t5_rrarb.sv - combinational round-robin arbiter, first request after pointer
module t5_rrarb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_idx
);

   logic [W-1:0] w_pos;
   logic         w_found;

   // Scan ptr+1 .. ptr+N (wrapping, N is a power of 2); ptr itself is checked last
   always_comb begin
      o_gnt   = '0;
      o_idx   = i_ptr;
      w_found = 1'b0;
      w_pos   = i_ptr;
      for (int k = 1; k <= N; k++) begin
         w_pos = i_ptr + k[W-1:0];
         if (!w_found && i_req[w_pos]) begin
            w_found      = 1'b1;
            o_gnt[w_pos] = 1'b1;
            o_idx        = w_pos;
         end
      end
   end

endmodule

// File: rtl/t5_fetch.sv
// rtl/t5_fetch.sv - multi-hart round-robin instruction fetch with per-hart redirect
module t5_fetch
   import t5_fetch_pkg::*;
#(
   parameter int               XLEN      = T5_XLEN,
   parameter int               HARTS     = T5_HARTS,
   parameter logic [XLEN-1:0]  RESET_VEC = T5_RESET_VEC,
   localparam int              HW        = $clog2(HARTS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [HARTS-1:0] hart_ena,
   input  logic            bra,
   input  logic [HW-1:0]   bra_hart,
   input  logic [XLEN-3:0] alu,
   t5_fetch_if.master      bus
);

   localparam logic [XLEN-3:0] ONE = {{(XLEN-3){1'b0}}, 1'b1};

   logic [XLEN-3:0] r_pctab [HARTS];
   logic [0:0]      r_state;
   logic            r_kill;
   logic [HW-1:0]   r_cur;
   logic [HW-1:0]   r_rr;
   logic            r_istb;
   logic [XLEN-3:0] r_iadr;
   logic            r_ovld;
   logic [XLEN-1:0] r_oinst;
   logic [XLEN-1:0] r_opc;
   logic [HW-1:0]   r_ohart;

   logic            w_busy;
   logic            w_cmp;
   logic            w_bra_cur;
   logic            w_can_issue;
   logic [HARTS-1:0] w_gnt;
   logic [HW-1:0]   w_sel;
   logic [XLEN-3:0] w_seq_pc;
   logic [XLEN-3:0] w_issue_pc;

   assign w_busy      = (r_state == ST_WAIT);
   assign w_cmp       = w_busy & bus.iack;
   assign w_bra_cur   = bra & (bra_hart == r_cur);
   assign w_can_issue = ~w_busy | bus.iack;
   assign w_seq_pc    = r_iadr + ONE;

   t5_rrarb #(.N(HARTS), .W(HW)) u_arb (
      .i_req (hart_ena),
      .i_ptr (r_rr),
      .o_gnt (w_gnt),
      .o_idx (w_sel)
   );

   // Address for a new fetch: same-cycle redirect or increment of the chosen hart wins over the table
   always_comb begin
      w_issue_pc = r_pctab[w_sel];
      if (bra && bra_hart == w_sel)
         w_issue_pc = alu;
      else if (w_cmp && !r_kill && !w_bra_cur && r_cur == w_sel)
         w_issue_pc = w_seq_pc;
   end

   // Per-hart PC table: redirect beats sequential advance; squashed fetches do not advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HARTS; i++)
            r_pctab[i] <= RESET_VEC[XLEN-1:2];
      end else begin
         for (int i = 0; i < HARTS; i++) begin
            if (bra && bra_hart == HW'(i))
               r_pctab[i] <= alu;
            else if (w_cmp && !r_kill && r_cur == HW'(i))
               r_pctab[i] <= w_seq_pc;
         end
      end
   end

   // Fetch FSM, bus strobe, scheduler pointer, kill tracking and decode-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_kill  <= 1'b0;
         r_cur   <= '0;
         r_rr    <= HW'(HARTS - 1);
         r_istb  <= 1'b0;
         r_iadr  <= '0;
         r_ovld  <= 1'b0;
         r_oinst <= '0;
         r_opc   <= '0;
         r_ohart <= '0;
      end else begin
         r_ovld <= 1'b0;
         if (w_cmp) begin
            r_ovld  <= ~r_kill & ~w_bra_cur;
            r_oinst <= bus.idat;
            r_opc   <= {r_iadr, 2'b00};
            r_ohart <= r_cur;
            r_kill  <= 1'b0;
         end else if (w_busy && w_bra_cur) begin
            r_kill  <= 1'b1;
         end
         if (w_can_issue) begin
            if (ena && |w_gnt) begin
               r_state <= ST_WAIT;
               r_istb  <= 1'b1;
               r_iadr  <= w_issue_pc;
               r_rr    <= w_sel;
               r_cur   <= w_sel;
            end else begin
               r_state <= ST_IDLE;
               r_istb  <= 1'b0;
            end
         end
      end
   end

   assign bus.istb  = r_istb;
   assign bus.iadr  = r_iadr;
   assign bus.ovld  = r_ovld;
   assign bus.oinst = r_oinst;
   assign bus.opc   = r_opc;
   assign bus.ohart = r_ohart;

endmodule
